// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared geometry defaults and FSM encoding for the instruction cache
package inst_cache_pkg;

    localparam int ICACHE_INDEX_WIDTH  = 7;
    localparam int ICACHE_OFFSET_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MISS_REQ = 2'd1,
        ST_REFILL   = 2'd2,
        ST_FINISH   = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_ram.sv
// rtl/icache_ram.sv - valid/tag/data storage with async read and sync word, tag and clear-all writes
module icache_ram #(
    parameter int INDEX_WIDTH    = 7,
    parameter int TAG_WIDTH      = 21,
    parameter int WORD_SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INDEX_WIDTH-1:0]    rd_index,
    input  logic [WORD_SEL_WIDTH-1:0] rd_word,
    output logic                      rd_valid,
    output logic [TAG_WIDTH-1:0]      rd_tag,
    output logic [31:0]               rd_data,
    input  logic [INDEX_WIDTH-1:0]    wr_index,
    input  logic                      word_we,
    input  logic [WORD_SEL_WIDTH-1:0] wr_word,
    input  logic [31:0]               wr_data,
    input  logic                      tag_we,
    input  logic [TAG_WIDTH-1:0]      wr_tag,
    input  logic                      clr_all
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << WORD_SEL_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [31:0]          data_mem [LINES*WORDS];

    // Clear-all wins so a pending invalidate also drops a line validated in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (tag_we) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (word_we) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with burst line refill
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        pause_o,
    input  logic        invalidate_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_ready_i,
    input  logic        ret_valid_i,
    input  logic [31:0] ret_data_i,
    input  logic        ret_last_i
);

    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WORD_SEL_WIDTH = OFFSET_WIDTH - 2;

    icache_state_e               state_q, state_d;
    logic [TAG_WIDTH-1:0]        line_tag_q, line_tag_d;
    logic [INDEX_WIDTH-1:0]      line_index_q, line_index_d;
    logic [WORD_SEL_WIDTH-1:0]   beat_q, beat_d;
    logic                        inv_pending_q, inv_pending_d;

    logic [TAG_WIDTH-1:0]        req_tag;
    logic [INDEX_WIDTH-1:0]      req_index;
    logic [WORD_SEL_WIDTH-1:0]   req_word;
    logic                        ram_valid;
    logic [TAG_WIDTH-1:0]        ram_tag;
    logic [31:0]                 ram_data;
    logic                        in_idle, hit, miss;
    logic                        word_we, tag_we, clr_all;
    logic                        unused_addr_bits;

    assign req_tag          = inst_addr_i[31 -: TAG_WIDTH];
    assign req_index        = inst_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_word         = inst_addr_i[2 +: WORD_SEL_WIDTH];
    assign unused_addr_bits = ^inst_addr_i[1:0];

    assign in_idle = (state_q == ST_IDLE);
    assign hit     = in_idle && inst_en_i && ram_valid && (ram_tag == req_tag);
    assign miss    = in_idle && inst_en_i && !(ram_valid && (ram_tag == req_tag));

    // Writes are gated by rst so an abandoned refill leaves nothing behind on the reset edge.
    assign word_we = !rst && (state_q == ST_REFILL) && ret_valid_i;
    assign tag_we  = word_we && ret_last_i;
    assign clr_all = (in_idle && invalidate_i)
                  || ((state_q == ST_FINISH) && (inv_pending_q || invalidate_i));

    icache_ram #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .TAG_WIDTH      (TAG_WIDTH),
        .WORD_SEL_WIDTH (WORD_SEL_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_valid (ram_valid),
        .rd_tag   (ram_tag),
        .rd_data  (ram_data),
        .wr_index (line_index_q),
        .word_we  (word_we),
        .wr_word  (beat_q),
        .wr_data  (ret_data_i),
        .tag_we   (tag_we),
        .wr_tag   (line_tag_q),
        .clr_all  (clr_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            line_tag_q    <= '0;
            line_index_q  <= '0;
            beat_q        <= '0;
            inv_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_tag_q    <= line_tag_d;
            line_index_q  <= line_index_d;
            beat_q        <= beat_d;
            inv_pending_q <= inv_pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (miss) state_d = ST_MISS_REQ;
            ST_MISS_REQ: if (rd_ready_i) state_d = ST_REFILL;
            ST_REFILL:   if (ret_valid_i && ret_last_i) state_d = ST_FINISH;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Beat counter wraps naturally at the line size; an invalidate outside IDLE is deferred to FINISH.
    always_comb begin
        line_tag_d    = line_tag_q;
        line_index_d  = line_index_q;
        beat_d        = beat_q;
        inv_pending_d = inv_pending_q;
        if (miss) begin
            line_tag_d   = req_tag;
            line_index_d = req_index;
        end
        if ((state_q == ST_MISS_REQ) && rd_ready_i) begin
            beat_d = '0;
        end else if (word_we) begin
            beat_d = beat_q + WORD_SEL_WIDTH'(1);
        end
        if (state_q == ST_FINISH) begin
            inv_pending_d = 1'b0;
        end else if (!in_idle && invalidate_i) begin
            inv_pending_d = 1'b1;
        end
    end

    always_comb begin
        rd_req_o     = (state_q == ST_MISS_REQ);
        rd_addr_o    = rd_req_o ? {line_tag_q, line_index_q, {OFFSET_WIDTH{1'b0}}} : 32'd0;
        pause_o      = !in_idle || miss;
        inst_valid_o = hit;
        inst_o       = hit ? ram_data : 32'd0;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the core's fetch port (`rom_inst_addr_o`/`rom_inst_en_o`/`rom_inst_i`) and the external instruction memory bus. Hits return the instruction combinationally in the fetch cycle, preserving existing `pc` → `if_id` timing. A miss raises `pause_o`, which feeds `ctrl` as an extra stall source, and runs a burst line refill over a valid/ready read channel. `invalidate_i` clears all lines for instruction-barrier use.

## Interface
- `INDEX_WIDTH`, default 7: line index bits (128 lines).
- `OFFSET_WIDTH`, default 4: byte offset bits (16-byte line, 4 words). Must be ≥ 3.
- Tag width is derived: 32 − `INDEX_WIDTH` − `OFFSET_WIDTH` (21 with the defaults).
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_en_i` in 1: fetch request, driven from `pc` `inst_en_o`.
- `inst_addr_i` in 32: fetch address. Bits [1:0] are ignored.
- `inst_o` out 32: instruction word. Valid only when `inst_valid_o` is 1; otherwise 0.
- `inst_valid_o` out 1: hit this cycle.
- `pause_o` out 1: stall request to `ctrl`.
- `invalidate_i` in 1: single-cycle pulse that invalidates all lines.
- `rd_req_o` out 1: line read request.
- `rd_addr_o` out 32: line-aligned address (offset bits are 0).
- `rd_ready_i` in 1: the bus accepts the request when `rd_req_o` and `rd_ready_i` are both 1.
- `ret_valid_i` in 1: return beat valid.
- `ret_data_i` in 32: return word.
- `ret_last_i` in 1: final beat of the burst.

## Operation
- Address split: tag = [31 : INDEX+OFFSET], index = [INDEX+OFFSET−1 : OFFSET], word = [OFFSET−1 : 2].
- Storage is read asynchronously and written synchronously: valid bit, tag, and 2^(OFFSET−2) words per line.
- **Hit:** state is IDLE, `inst_en_i`=1, valid[index]=1 and tag matches. Then `inst_valid_o`=1, `inst_o` = data[index][word], `pause_o`=0.
- **Miss:** state is IDLE, `inst_en_i`=1, and no hit.
  - `pause_o`=1 in the same cycle.
  - Latch the line address and index, then go to MISS_REQ.
- **States:**
  - IDLE: lookup as above. `inst_en_i`=0 gives no lookup, `pause_o`=0 and `inst_valid_o`=0.
  - MISS_REQ: `rd_req_o`=1 and `rd_addr_o` = latched line address, both held stable until `rd_ready_i`=1. Then clear the beat counter and go to REFILL.
  - REFILL: on each `ret_valid_i`, write `ret_data_i` to data[latched index][beat], then beat+1 (wraps modulo words per line). On `ret_valid_i` with `ret_last_i`, write the latched tag and valid=1, then go to FINISH.
  - FINISH: one cycle, `pause_o`=1, then IDLE. Lookup replays in IDLE and hits.
- `pause_o`=1 in every non-IDLE state. `inst_valid_o`=0 in every non-IDLE state.
- `inst_addr_i` is ignored outside IDLE. Refill always uses the latched address.
- `ret_valid_i` outside REFILL is ignored.
- Early `ret_last_i` validates the line with whatever words were written. Software and the bus contract forbid this case; it is not an error.
- **`invalidate_i` in IDLE:** clears all valid bits at the edge. The lookup in that same cycle still uses the old contents.
- **`invalidate_i` during MISS_REQ, REFILL or FINISH:** sets `inv_pending`. At the FINISH → IDLE edge, all valid bits are cleared, including the new line, and `inv_pending` is cleared. The replay then misses again.
- **Reset:** state IDLE, all valid bits 0, `inv_pending` 0, beat 0. Data and tag arrays are not reset.
- **Reset mid-refill:** the refill is abandoned and nothing is validated. The bus side is reset by the same `rst`.

## Timing
- Outputs after reset: `rd_req_o`=0, `rd_addr_o`=0, `pause_o`=0, `inst_valid_o`=0, `inst_o`=0.
- Hit latency: 0 cycles, combinational from `inst_addr_i`.
- Miss penalty, with `rd_ready_i`=1 immediately and back-to-back beats (W = words per line):
  - cycle 0: miss detected.
  - cycle 1: MISS_REQ handshake.
  - cycles 2 … W+1: beats.
  - cycle W+2: FINISH.
  - cycle W+3: hit.
  - `pause_o` is 1 for cycles 0 … W+2; with defaults that is 7 cycles.
- Each cycle of bus wait (late `rd_ready_i` or gaps in `ret_valid_i`) adds exactly one cycle to the penalty.
- At most one outstanding request.

## Structure
- Add to `define.v`:
  - `ICacheIndexWidth` and `ICacheOffsetWidth` macros.
  - State encodings: IDLE=2'd0, MISS_REQ=2'd1, REFILL=2'd2, FINISH=2'd3.
- Add one sub-module `icache_ram`:
  - valid, tag and data arrays.
  - Async read port: index → valid, tag, line words.
  - Sync write port: word write; tag+valid write; clear-all.
- `inst_cache` holds the FSM, latches, beat counter, `inv_pending` and hit logic.
- Top-level integration: `pause_o` is ORed into `ctrl` as an additional fetch stall source.

## Test plan
- **Cold miss then hit:** reset; fetch 0x1C000000 with bus returning 0xA0,0xA1,0xA2,0xA3 (last on 4th).
  - `rd_addr_o`=0x1C000000 on handshake; `pause_o` for 7 cycles.
  - Then `inst_valid_o`=1, `inst_o`=0xA0.
  - Following fetch 0x1C00000C hits with 0xA3 and 0 pause.
- **Conflict:** fetch 0x00000010 then 0x00000810 (same index, different tag).
  - Second fetch misses and refills.
  - Re-fetching 0x00000010 misses again.
- **Backpressure:** hold `rd_ready_i`=0 for 5 cycles, insert 2 idle gaps between beats.
  - `rd_req_o`/`rd_addr_o` stay stable throughout.
  - `pause_o` lasts 7+5+2=14 cycles.
- **Invalidate:**
  - Pulse in IDLE after line loaded → next fetch of that line misses.
  - Pulse during REFILL → replay after FINISH misses and a second refill occurs.
- **Reset mid-refill:** assert `rst` after 2 beats.
  - Next cycle all outputs are 0.
  - Fetch of the same address misses.
- **`inst_en_i`=0** with valid hit address → `inst_valid_o`=0, `pause_o`=0, no bus request.
